l1_mem_arbiter: RTL and testbench
=================================

L1_MEM_ARBITER -- requirements
Module: l1_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, physical line address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache line data width.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_pmem_read  in  1  I-cache line fill request, held until i_pmem_resp.
REQ-006 SHALL have port i_pmem_addr  in  ADDR_W  I-cache request address.
REQ-007 SHALL have port i_pmem_rdata  out  LINE_W  fill data returned to I-cache.
REQ-008 SHALL have port i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
REQ-009 SHALL have port d_pmem_read  in  1  D-cache line fill request, held until d_pmem_resp.
REQ-010 SHALL have port d_pmem_write  in  1  D-cache writeback request, held until d_pmem_resp.
REQ-011 SHALL have port d_pmem_addr  in  ADDR_W  D-cache request address.
REQ-012 SHALL have port d_pmem_wdata  in  LINE_W  D-cache writeback data.
REQ-013 SHALL have port d_pmem_rdata  out  LINE_W  fill data returned to D-cache.
REQ-014 SHALL have port d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
REQ-015 SHALL have port l2_read  out  1  read request to shared L2/memory.
REQ-016 SHALL have port l2_write  out  1  write request to shared L2/memory.
REQ-017 SHALL have port l2_addr  out  ADDR_W  registered address to L2.
REQ-018 SHALL have port l2_wdata  out  LINE_W  registered write data to L2.
REQ-019 SHALL have port l2_rdata  in  LINE_W  L2 read data, valid with l2_resp.
REQ-020 SHALL have port l2_resp  in  1  L2 completion pulse.
REQ-021 SHALL have port arb_conflict_sig  out  1  perf pulse: both caches requesting in IDLE.
REQ-022 SHALL have port conflict_count  out  16  saturating count of arb_conflict_sig pulses.

Function
REQ-023 SHALL implement states IDLE, SERVE_I, SERVE_D, with one L2 transaction outstanding at most.
REQ-024 IDLE: i request only -> SERVE_I; d request only -> SERVE_D; none -> IDLE.
REQ-025 IDLE, both requesting: grant the cache not granted last (last_grant flop), assert arb_conflict_sig that cycle.
REQ-026 On grant, SHALL latch address, op (read/write) and wdata into l2_addr/l2_wdata/op registers; last_grant updated.
REQ-027 l2_read/l2_write SHALL be asserted (from registers) for every cycle in SERVE_x, first asserted the cycle after the request is sampled in IDLE.
REQ-028 d_pmem_write and d_pmem_read both high: write SHALL be taken, read ignored for that grant.
REQ-029 SERVE_x with l2_resp=1: x_pmem_resp=1 same cycle (combinational), x_pmem_rdata=l2_rdata, next state IDLE.
REQ-030 x_pmem_rdata SHALL be l2_rdata at all times; only x_pmem_resp qualifies it; non-granted resp stays 0.
REQ-031 Back-to-back: minimum one IDLE cycle between l2_resp and the next l2_read/l2_write.
REQ-032 Requester dropping its request before l2_resp: SHALL NOT abort; L2 held until l2_resp, resp pulse still issued.
REQ-033 l2_resp in IDLE SHALL be ignored, no resp pulse, no state change.
REQ-034 Latched address/wdata SHALL NOT change while in SERVE_x, even if inputs change.
REQ-035 conflict_count SHALL increment on each arb_conflict_sig, saturating at 16'hFFFF.

Reset
REQ-036 rst_n low, at any time incl. mid-transaction: state=IDLE, l2_read=l2_write=0, l2_addr=0, l2_wdata=0, both resp=0, last_grant=I, conflict_count=0, arb_conflict_sig=0, immediately and asynchronously.
REQ-037 After rst_n release, first conflict SHALL be granted to D.

Verification
REQ-038 I read addr 0x0000_1000 alone, l2_resp after 3 cycles -> l2_read high cycles 1-4 with l2_addr 0x1000, i_pmem_resp pulse in cycle 4, d_pmem_resp 0.
REQ-039 D write addr 0x2000, wdata 0xA5 pattern -> l2_write=1, l2_wdata=0xA5 pattern, d_pmem_resp on l2_resp, then IDLE.
REQ-040 I and D request same cycle after reset -> D served first, arb_conflict_sig=1, conflict_count=1; I served next after one IDLE cycle.
REQ-041 D writeback then D fill while I pending -> order D-write, I-read, D-read (round robin).
REQ-042 rst_n asserted during SERVE_D before l2_resp -> outputs zero that cycle, no d_pmem_resp; later l2_resp ignored.
REQ-043 0xFFFF conflicts then one more -> conflict_count stays 0xFFFF.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
//   Arbitrates between an I-cache and a D-cache for one shared L2/memory port.
//   At most one L2 transaction is outstanding at a time. When both caches
//   request in the same IDLE cycle, the cache that was not granted last wins.
//   A per-cycle conflict pulse goes out on arb_conflict_sig, and a saturating
//   counter (conflict_count) tracks how many conflicts have occurred.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_pmem_read/addr              I-cache fill request (held until i_pmem_resp)
//   i_pmem_rdata/resp             I-cache fill data and completion pulse
//   d_pmem_read/write/addr/wdata  D-cache fill/writeback request
//   d_pmem_rdata/resp             D-cache fill data and completion pulse
//   l2_read/write/addr/wdata      registered request to L2
//   l2_rdata/resp                 L2 read data and completion pulse
//   arb_conflict_sig              both caches requesting while IDLE
//   conflict_count                saturating count of conflict pulses
module l1_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_addr,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_addr,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,

    output logic              arb_conflict_sig,
    output logic [15:0]       conflict_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StServeI = 2'd1,
        StServeD = 2'd2
    } state_e;

    state_e            state_q;
    logic              last_grant_d_q;  // 1: D was granted last, 0: I was
    logic              l2_read_q;
    logic              l2_write_q;
    logic [ADDR_W-1:0] l2_addr_q;
    logic [LINE_W-1:0] l2_wdata_q;
    logic [15:0]       conflict_count_q;

    logic i_req;
    logic d_req;
    logic conflict_raw;
    logic grant_d;

    always_comb begin
        i_req        = i_pmem_read;
        d_req        = d_pmem_read | d_pmem_write;
        conflict_raw = (state_q == StIdle) & i_req & d_req;
        // D wins when alone, or on a conflict if I was granted last.
        grant_d      = d_req & (~i_req | ~last_grant_d_q);
    end

    // Responses are combinational on l2_resp so the cache sees completion in
    // the same cycle the data is valid.
    always_comb begin
        i_pmem_rdata     = l2_rdata;
        d_pmem_rdata     = l2_rdata;
        i_pmem_resp      = (state_q == StServeI) & l2_resp;
        d_pmem_resp      = (state_q == StServeD) & l2_resp;
        // Gated by rst_n so requests held during reset never show a conflict.
        arb_conflict_sig = conflict_raw & rst_n;
        l2_read          = l2_read_q;
        l2_write         = l2_write_q;
        l2_addr          = l2_addr_q;
        l2_wdata         = l2_wdata_q;
        conflict_count   = conflict_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            last_grant_d_q   <= 1'b0;
            l2_read_q        <= 1'b0;
            l2_write_q       <= 1'b0;
            l2_addr_q        <= '0;
            l2_wdata_q       <= '0;
            conflict_count_q <= '0;
        end else begin
            if (conflict_raw && (conflict_count_q != 16'hFFFF)) begin
                conflict_count_q <= conflict_count_q + 16'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        state_q        <= StServeD;
                        last_grant_d_q <= 1'b1;
                        l2_addr_q      <= d_pmem_addr;
                        l2_wdata_q     <= d_pmem_wdata;
                        // A writeback takes priority over a simultaneous fill.
                        l2_write_q     <= d_pmem_write;
                        l2_read_q      <= ~d_pmem_write;
                    end else if (i_req) begin
                        state_q        <= StServeI;
                        last_grant_d_q <= 1'b0;
                        l2_addr_q      <= i_pmem_addr;
                        l2_read_q      <= 1'b1;
                        l2_write_q     <= 1'b0;
                    end
                end
                StServeI, StServeD: begin
                    // No abort path: the transaction runs to l2_resp even if
                    // the requester drops its request.
                    if (l2_resp) begin
                        state_q    <= StIdle;
                        l2_read_q  <= 1'b0;
                        l2_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    l2_read_q  <= 1'b0;
                    l2_write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Testbench for l1_mem_arbiter: directed scenarios followed by a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_l1_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_addr;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_addr;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic              arb_conflict_sig;
    logic [15:0]       conflict_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l1_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_pmem_read     (i_pmem_read),
        .i_pmem_addr     (i_pmem_addr),
        .i_pmem_rdata    (i_pmem_rdata),
        .i_pmem_resp     (i_pmem_resp),
        .d_pmem_read     (d_pmem_read),
        .d_pmem_write    (d_pmem_write),
        .d_pmem_addr     (d_pmem_addr),
        .d_pmem_wdata    (d_pmem_wdata),
        .d_pmem_rdata    (d_pmem_rdata),
        .d_pmem_resp     (d_pmem_resp),
        .l2_read         (l2_read),
        .l2_write        (l2_write),
        .l2_addr         (l2_addr),
        .l2_wdata        (l2_wdata),
        .l2_rdata        (l2_rdata),
        .l2_resp         (l2_resp),
        .arb_conflict_sig(arb_conflict_sig),
        .conflict_count  (conflict_count)
    );

    // Inputs change 1 time unit after the rising edge; checks happen 4 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_pmem_read  = 1'b0;
        i_pmem_addr  = '0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_addr  = '0;
        d_pmem_wdata = '0;
        l2_rdata     = '0;
        l2_resp      = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        l2_resp     = 1'b1;
        #4;
        checks++; if (l2_read !== 1'b0) begin errors++;
            $display("FAIL reset_l2_read: got %0b expected 0", l2_read); end
        checks++; if (l2_write !== 1'b0) begin errors++;
            $display("FAIL reset_l2_write: got %0b expected 0", l2_write); end
        checks++; if (l2_addr !== '0) begin errors++;
            $display("FAIL reset_l2_addr: got %0h expected 0", l2_addr); end
        checks++; if (l2_wdata !== '0) begin errors++;
            $display("FAIL reset_l2_wdata: got %0h expected 0", l2_wdata); end
        checks++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin errors++;
            $display("FAIL reset_resp: got i=%0b d=%0b expected 0/0", i_pmem_resp, d_pmem_resp); end
        checks++; if (arb_conflict_sig !== 1'b0) begin errors++;
            $display("FAIL reset_conflict: got %0b expected 0", arb_conflict_sig); end
        checks++; if (conflict_count !== 16'h0) begin errors++;
            $display("FAIL reset_count: got %0h expected 0", conflict_count); end
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // I fill alone at 0x1000, L2 answers on the 4th serve cycle.
    task automatic test_i_read();
        logic [LINE_W-1:0] rd;
        logic              busy;
        for (int c = 0; c <= 5; c++) begin
            rd          = {8{$urandom}};
            busy        = (c >= 1 && c <= 4);
            i_pmem_read = (c <= 4);
            i_pmem_addr = 32'h0000_1000;
            l2_resp     = (c == 4);
            l2_rdata    = rd;
            #4;
            checks++; if (l2_read !== busy) begin errors++;
                $display("FAIL iread_l2_read c%0d: got %0b expected %0b", c, l2_read, busy); end
            checks++; if (l2_write !== 1'b0) begin errors++;
                $display("FAIL iread_l2_write c%0d: got %0b expected 0", c, l2_write); end
            if (busy) begin
                checks++; if (l2_addr !== 32'h0000_1000) begin errors++;
                    $display("FAIL iread_addr c%0d: got %0h expected 1000", c, l2_addr); end
            end
            checks++; if (i_pmem_resp !== (c == 4)) begin errors++;
                $display("FAIL iread_iresp c%0d: got %0b expected %0b", c, i_pmem_resp, c == 4); end
            checks++; if (d_pmem_resp !== 1'b0) begin errors++;
                $display("FAIL iread_dresp c%0d: got %0b expected 0", c, d_pmem_resp); end
            checks++; if (i_pmem_rdata !== rd) begin errors++;
                $display("FAIL iread_rdata c%0d: got %0h expected %0h", c, i_pmem_rdata, rd); end
            step();
        end
        idle_inputs();
    endtask

    // D writeback; inputs are scrambled once granted to prove the latch holds.
    task automatic test_d_write();
        logic [LINE_W-1:0] pat;
        logic              busy;
        pat = {32{8'hA5}};
        for (int c = 0; c <= 4; c++) begin
            busy         = (c >= 1 && c <= 3);
            d_pmem_write = (c <= 3);
            d_pmem_addr  = (c == 0) ? 32'h0000_2000 : $urandom;
            d_pmem_wdata = (c == 0) ? pat : ~pat;
            l2_resp      = (c == 3);
            #4;
            checks++; if (l2_write !== busy) begin errors++;
                $display("FAIL dwrite_l2_write c%0d: got %0b expected %0b", c, l2_write, busy); end
            checks++; if (l2_read !== 1'b0) begin errors++;
                $display("FAIL dwrite_l2_read c%0d: got %0b expected 0", c, l2_read); end
            if (busy) begin
                checks++; if (l2_addr !== 32'h0000_2000) begin errors++;
                    $display("FAIL dwrite_addr c%0d: got %0h expected 2000", c, l2_addr); end
                checks++; if (l2_wdata !== pat) begin errors++;
                    $display("FAIL dwrite_wdata c%0d: got %0h expected %0h", c, l2_wdata, pat); end
            end
            checks++; if (d_pmem_resp !== (c == 3)) begin errors++;
                $display("FAIL dwrite_dresp c%0d: got %0b expected %0b", c, d_pmem_resp, c == 3); end
            checks++; if (i_pmem_resp !== 1'b0) begin errors++;
                $display("FAIL dwrite_iresp c%0d: got %0b expected 0", c, i_pmem_resp); end
            step();
        end
        idle_inputs();
    endtask

    // Simultaneous requests right after reset: D first, then I after one IDLE.
    task automatic test_conflict();
        logic [4:0]        ird, drd, rsp, erd, econf, eir, edr;
        logic [ADDR_W-1:0] eaddr [5];
        logic [15:0]       ecnt;
        apply_reset();
        ird = 5'b01111; drd = 5'b00011; rsp = 5'b01010;
        erd = 5'b01010; econf = 5'b00001; eir = 5'b01000; edr = 5'b00010;
        eaddr[0] = '0; eaddr[1] = 32'h4000; eaddr[2] = '0; eaddr[3] = 32'h3000; eaddr[4] = '0;
        for (int c = 0; c < 5; c++) begin
            i_pmem_read = ird[c];
            i_pmem_addr = 32'h3000;
            d_pmem_read = drd[c];
            d_pmem_addr = 32'h4000;
            l2_resp     = rsp[c];
            ecnt        = (c == 0) ? 16'd0 : 16'd1;
            #4;
            checks++; if (l2_read !== erd[c]) begin errors++;
                $display("FAIL conf_l2_read c%0d: got %0b expected %0b", c, l2_read, erd[c]); end
            if (erd[c]) begin
                checks++; if (l2_addr !== eaddr[c]) begin errors++;
                    $display("FAIL conf_addr c%0d: got %0h expected %0h", c, l2_addr, eaddr[c]); end
            end
            checks++; if (arb_conflict_sig !== econf[c]) begin errors++;
                $display("FAIL conf_sig c%0d: got %0b expected %0b", c, arb_conflict_sig, econf[c]); end
            checks++; if (conflict_count !== ecnt) begin errors++;
                $display("FAIL conf_count c%0d: got %0h expected %0h", c, conflict_count, ecnt); end
            checks++; if (i_pmem_resp !== eir[c] || d_pmem_resp !== edr[c]) begin errors++;
                $display("FAIL conf_resp c%0d: got i=%0b d=%0b expected i=%0b d=%0b",
                         c, i_pmem_resp, d_pmem_resp, eir[c], edr[c]); end
            step();
        end
        idle_inputs();
    endtask

    // D writeback, then D fill while I waits: order D-write, I-read, D-read.
    task automatic test_round_robin();
        logic [6:0]        ird, dwr, drd, rsp, erd, ewr, econf, eir, edr;
        logic [ADDR_W-1:0] eaddr [7];
        apply_reset();
        ird = 7'b0001111; dwr = 7'b0000011; drd = 7'b0111100; rsp = 7'b0101010;
        erd = 7'b0101000; ewr = 7'b0000010; econf = 7'b0000101;
        eir = 7'b0001000; edr = 7'b0100010;
        for (int c = 0; c < 7; c++) eaddr[c] = '0;
        eaddr[1] = 32'h6000; eaddr[3] = 32'h5000; eaddr[5] = 32'h7000;
        for (int c = 0; c < 7; c++) begin
            i_pmem_read  = ird[c];
            i_pmem_addr  = 32'h5000;
            d_pmem_write = dwr[c];
            d_pmem_read  = drd[c];
            d_pmem_addr  = dwr[c] ? 32'h6000 : 32'h7000;
            d_pmem_wdata = {8{32'hDEAD_BEEF}};
            l2_resp      = rsp[c];
            #4;
            checks++; if (l2_read !== erd[c] || l2_write !== ewr[c]) begin errors++;
                $display("FAIL rr_op c%0d: got r=%0b w=%0b expected r=%0b w=%0b",
                         c, l2_read, l2_write, erd[c], ewr[c]); end
            if (erd[c] || ewr[c]) begin
                checks++; if (l2_addr !== eaddr[c]) begin errors++;
                    $display("FAIL rr_addr c%0d: got %0h expected %0h", c, l2_addr, eaddr[c]); end
            end
            checks++; if (arb_conflict_sig !== econf[c]) begin errors++;
                $display("FAIL rr_conf c%0d: got %0b expected %0b", c, arb_conflict_sig, econf[c]); end
            checks++; if (i_pmem_resp !== eir[c] || d_pmem_resp !== edr[c]) begin errors++;
                $display("FAIL rr_resp c%0d: got i=%0b d=%0b expected i=%0b d=%0b",
                         c, i_pmem_resp, d_pmem_resp, eir[c], edr[c]); end
            step();
        end
        idle_inputs();
    endtask

    // Reset lands during SERVE_D; a late l2_resp must then be ignored.
    task automatic test_reset_mid();
        d_pmem_read = 1'b1;
        d_pmem_addr = 32'h8000;
        step();
        #4;
        checks++; if (l2_read !== 1'b1 || l2_addr !== 32'h8000) begin errors++;
            $display("FAIL rmid_serving: got r=%0b a=%0h expected r=1 a=8000", l2_read, l2_addr); end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (l2_read !== 1'b0 || l2_addr !== '0) begin errors++;
            $display("FAIL rmid_async: got r=%0b a=%0h expected r=0 a=0", l2_read, l2_addr); end
        l2_resp = 1'b1;
        #1;
        checks++; if (d_pmem_resp !== 1'b0) begin errors++;
            $display("FAIL rmid_dresp_in_reset: got %0b expected 0", d_pmem_resp); end
        step();
        rst_n       = 1'b1;
        d_pmem_read = 1'b0;
        l2_resp     = 1'b1;
        #4;
        checks++; if (d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin errors++;
            $display("FAIL rmid_idle_resp: got d=%0b i=%0b expected 0/0", d_pmem_resp, i_pmem_resp); end
        step();
        l2_resp = 1'b0;
        #4;
        checks++; if (l2_read !== 1'b0 || l2_write !== 1'b0) begin errors++;
            $display("FAIL rmid_stay_idle: got r=%0b w=%0b expected 0/0", l2_read, l2_write); end
        step();
        idle_inputs();
    endtask

    // Preload the counter near the top, then keep both caches conflicting.
    task automatic test_saturation();
        logic [15:0] ecnt;
        logic        econf;
        apply_reset();
        force dut.conflict_count_q = 16'hFFFD;
        #1;
        release dut.conflict_count_q;
        ecnt        = 16'hFFFD;
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        l2_resp     = 1'b1;
        for (int c = 0; c < 8; c++) begin
            econf = (c % 2 == 0);
            #3;
            checks++; if (arb_conflict_sig !== econf) begin errors++;
                $display("FAIL sat_conf c%0d: got %0b expected %0b", c, arb_conflict_sig, econf); end
            checks++; if (conflict_count !== ecnt) begin errors++;
                $display("FAIL sat_count c%0d: got %0h expected %0h", c, conflict_count, ecnt); end
            if (econf && ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
            step();
        end
        idle_inputs();
        step();
    endtask

    // Random traffic against a transaction-level model of the arbiter.
    task automatic test_random();
        bit                m_busy, m_who, m_opw, m_last;  // who/last: 1 = D
        logic [ADDR_W-1:0] m_addr;
        logic [LINE_W-1:0] m_wdata;
        logic [15:0]       m_cnt;
        int unsigned       m_lat, k;
        bit                i_pend, d_pend, d_wr, d_rd;
        bit                i_req, d_req, d_win, e_rd, e_wr, e_conf, e_ir, e_dr;
        apply_reset();
        m_busy = 0; m_who = 0; m_opw = 0; m_last = 0; m_addr = '0; m_wdata = '0;
        m_cnt = '0; m_lat = 0; i_pend = 0; d_pend = 0; d_wr = 0; d_rd = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!i_pend && $urandom_range(2) == 0) i_pend = 1;
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1;
                k      = $urandom_range(2);
                d_wr   = (k != 0);
                d_rd   = (k != 1);
            end
            i_pmem_read  = i_pend;
            i_pmem_addr  = $urandom;
            d_pmem_read  = d_pend && d_rd;
            d_pmem_write = d_pend && d_wr;
            d_pmem_addr  = $urandom;
            d_pmem_wdata = {8{$urandom}};
            l2_rdata     = {8{$urandom}};
            if (m_busy) begin
                l2_resp = (m_lat == 0);
                if (m_lat != 0) m_lat--;
            end else begin
                l2_resp = ($urandom_range(7) == 0);
            end
            i_req  = i_pmem_read;
            d_req  = d_pmem_read || d_pmem_write;
            e_rd   = m_busy && !m_opw;
            e_wr   = m_busy && m_opw;
            e_conf = !m_busy && i_req && d_req;
            e_ir   = m_busy && !m_who && l2_resp;
            e_dr   = m_busy && m_who && l2_resp;
            #4;
            checks++; if (l2_read !== e_rd || l2_write !== e_wr) begin errors++;
                $display("FAIL rnd_op n%0d: got r=%0b w=%0b expected r=%0b w=%0b",
                         n, l2_read, l2_write, e_rd, e_wr); end
            if (m_busy) begin
                checks++; if (l2_addr !== m_addr) begin errors++;
                    $display("FAIL rnd_addr n%0d: got %0h expected %0h", n, l2_addr, m_addr); end
            end
            if (e_wr) begin
                checks++; if (l2_wdata !== m_wdata) begin errors++;
                    $display("FAIL rnd_wdata n%0d: got %0h expected %0h", n, l2_wdata, m_wdata); end
            end
            checks++; if (arb_conflict_sig !== e_conf) begin errors++;
                $display("FAIL rnd_conf n%0d: got %0b expected %0b", n, arb_conflict_sig, e_conf); end
            checks++; if (conflict_count !== m_cnt) begin errors++;
                $display("FAIL rnd_count n%0d: got %0h expected %0h", n, conflict_count, m_cnt); end
            checks++; if (i_pmem_resp !== e_ir || d_pmem_resp !== e_dr) begin errors++;
                $display("FAIL rnd_resp n%0d: got i=%0b d=%0b expected i=%0b d=%0b",
                         n, i_pmem_resp, d_pmem_resp, e_ir, e_dr); end
            checks++; if (i_pmem_rdata !== l2_rdata || d_pmem_rdata !== l2_rdata) begin errors++;
                $display("FAIL rnd_rdata n%0d: got i=%0h d=%0h expected %0h",
                         n, i_pmem_rdata, d_pmem_rdata, l2_rdata); end
            if (m_busy) begin
                if (l2_resp) begin
                    m_busy = 0;
                    if (m_who) d_pend = 0;
                    else i_pend = 0;
                end
            end else if (i_req || d_req) begin
                d_win = d_req && (!i_req || !m_last);
                if (e_conf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_busy = 1;
                m_who  = d_win;
                m_last = d_win;
                m_opw  = d_win && d_pmem_write;
                m_addr = d_win ? d_pmem_addr : i_pmem_addr;
                if (d_win) m_wdata = d_pmem_wdata;
                m_lat  = $urandom_range(4);
            end
            // Occasional early drop: the arbiter must still finish the transfer.
            if (i_pend && $urandom_range(15) == 0) i_pend = 0;
            if (d_pend && $urandom_range(15) == 0) d_pend = 0;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_i_read();
        test_d_write();
        test_conflict();
        test_round_robin();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
